// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared parameters and FSM state encoding for the data cache
package dcache_pkg;
    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 8;
    localparam int INDEX_W    = 3;
    localparam int OFFSET_W   = 2;
    localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
    localparam int BLOCK_W    = 32;
    localparam int LINES      = 1 << INDEX_W;
    localparam int BLK_ADDR_W = ADDR_W - OFFSET_W;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_BACK = 2'd1,
        FETCH      = 2'd2,
        UPDATE     = 2'd3
    } state_t;
endpackage

// File: rtl/dcache_stats.sv
// rtl/dcache_stats.sv - saturating hit/miss counters for the data cache
// Ports: clk, reset_n (async active-low), hit_inc/miss_inc (one-cycle pulses),
//        hit_count/miss_count (saturating at all-ones).
module dcache_stats
    import dcache_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             hit_inc,
    input  logic             miss_inc,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_inc && hit_count != '1)
                hit_count <= hit_count + 1'b1;
            if (miss_inc && miss_count != '1)
                miss_count <= miss_count + 1'b1;
        end
    end
endmodule

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-back write-allocate data cache
// CPU side: read/write/address/writedata in, readdata/busywait out.
// Memory side: mem_read/mem_write/mem_address/mem_writedata out,
//              mem_readdata/mem_busywait in (whole 4-byte blocks, byte0 in [7:0]).
// clk rising edge; reset_n asynchronous active-low.
// Optional DCACHE_STATS_EN: adds hit_count/miss_count outputs (saturating).
module dcache_controller
    import dcache_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W-1:0]     writedata,
    output logic [DATA_W-1:0]     readdata,
    output logic                  busywait,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [BLK_ADDR_W-1:0] mem_address,
    output logic [BLOCK_W-1:0]    mem_writedata,
    input  logic [BLOCK_W-1:0]    mem_readdata,
    input  logic                  mem_busywait
`ifdef DCACHE_STATS_EN
    ,
    output logic [CNT_W-1:0]      hit_count,
    output logic [CNT_W-1:0]      miss_count
`endif
);
    logic [BLOCK_W-1:0] data_array [LINES];
    logic [TAG_W-1:0]   tag_array  [LINES];
    logic [LINES-1:0]   valid;
    logic [LINES-1:0]   dirty;

    state_t state, state_next;

    logic [INDEX_W-1:0]  idx;
    logic [TAG_W-1:0]    tag;
    logic [OFFSET_W-1:0] off;
    logic                req;
    logic                hit;
    logic                idle_hit;
    logic                miss_start;

    assign idx      = address[OFFSET_W +: INDEX_W];
    assign tag      = address[ADDR_W-1 -: TAG_W];
    assign off      = address[OFFSET_W-1:0];
    assign req      = read | write;
    assign hit      = valid[idx] && (tag_array[idx] == tag);
    assign idle_hit = (state == IDLE) && req && hit;

    always_comb begin
        state_next    = state;
        busywait      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        readdata      = '0;
        miss_start    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        // A store wins when both strobes are high, so no load data.
                        if (!write)
                            readdata = data_array[idx][{off, 3'b000} +: DATA_W];
                    end else begin
                        busywait   = 1'b1;
                        miss_start = 1'b1;
                        state_next = dirty[idx] ? WRITE_BACK : FETCH;
                    end
                end
            end
            WRITE_BACK: begin
                busywait      = 1'b1;
                mem_write     = 1'b1;
                mem_address   = {tag_array[idx], idx};
                mem_writedata = data_array[idx];
                if (!mem_busywait)
                    state_next = FETCH;
            end
            FETCH: begin
                busywait    = 1'b1;
                mem_read    = 1'b1;
                mem_address = address[ADDR_W-1:OFFSET_W];
                if (!mem_busywait)
                    state_next = UPDATE;
            end
            UPDATE: begin
                busywait   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Data and tags carry no reset: valid bits alone decide whether a line is usable.
    always_ff @(posedge clk) begin
        if (idle_hit && write)
            data_array[idx][{off, 3'b000} +: DATA_W] <= writedata;
        else if (state == UPDATE) begin
            data_array[idx] <= mem_readdata;
            tag_array[idx]  <= tag;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            valid <= '0;
            dirty <= '0;
        end else begin
            state <= state_next;
            if (state == UPDATE) begin
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b0;
            end else if (idle_hit && write)
                dirty[idx] <= 1'b1;
        end
    end

`ifdef DCACHE_STATS_EN
    // Marks that the pending access already missed, so its completion after
    // the refill is not also counted as a hit.
    logic missed;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            missed <= 1'b0;
        else if (miss_start)
            missed <= 1'b1;
        else if (state == IDLE)
            missed <= 1'b0;
    end

    dcache_stats u_stats (
        .clk        (clk),
        .reset_n    (reset_n),
        .hit_inc    (idle_hit && !missed),
        .miss_inc   (miss_start),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );
`endif
endmodule
